// File: rtl/rgmii_link_ctrl.sv
// rtl/rgmii_link_ctrl.sv - RGMII in-band status qualifier and speed-switch sequencer
// Filters idle-period link status, then drives speed/link/duplex with a MAC reset hold around speed changes.
module rgmii_link_ctrl #(
  parameter int unsigned STABLE_COUNT  = 16,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic       cfg_force_en,
  input  logic [1:0] cfg_force_speed,
  output logic [1:0] speed,
  output logic       link_up,
  output logic       full_duplex,
  output logic       mac_rst,
  output logic       speed_change
);

  typedef enum logic [1:0] {S_DOWN, S_UP, S_DRAIN, S_SETTLE} state_t;

  localparam logic [7:0] C_STABLE    = 8'(STABLE_COUNT);
  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_cand_link;
  logic [1:0] r_cand_speed;
  logic       r_cand_duplex;
  logic [7:0] r_cnt;

  logic [1:0] r_speed;
  logic       r_link_up;
  logic       r_full_duplex;
  logic       r_mac_rst;
  logic       r_speed_change;
  logic [1:0] r_pending;
  logic [7:0] r_hold;

  logic [1:0] w_speed_nxt;
  logic       w_link_up_nxt;
  logic       w_full_duplex_nxt;
  logic       w_mac_rst_nxt;
  logic       w_speed_change_nxt;
  logic [1:0] w_pending_nxt;
  logic [7:0] w_hold_nxt;

  logic       w_idle;
  logic       w_reserved;
  logic       w_same;
  logic       w_qualified;
  logic       w_hold_done;
  logic [1:0] w_force_speed;
  logic [1:0] w_tgt;
  logic       w_unused;

  assign w_idle        = !gmii_rx_dv && !gmii_rx_er;
  assign w_reserved    = (gmii_rxd[2:1] == 2'b11);
  assign w_same        = ({gmii_rxd[0], gmii_rxd[2:1], gmii_rxd[3]} ==
                          {r_cand_link, r_cand_speed, r_cand_duplex});
  assign w_qualified   = (r_cnt == C_STABLE);
  assign w_hold_done   = (r_hold == C_HOLD_LAST);
  assign w_force_speed = (cfg_force_speed == 2'b11) ? 2'b10 : cfg_force_speed;
  assign w_tgt         = cfg_force_en ? w_force_speed : r_cand_speed;
  assign w_unused      = ^gmii_rxd[7:4];

  // Status sampled only between frames; frames and errors freeze the filter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand_link   <= 1'b0;
      r_cand_speed  <= 2'b00;
      r_cand_duplex <= 1'b0;
      r_cnt         <= 8'd0;
    end else if (w_idle) begin
      if (w_reserved) begin
        r_cnt <= 8'd0;
      end else if (w_same) begin
        if (r_cnt < C_STABLE) r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cand_link   <= gmii_rxd[0];
        r_cand_speed  <= gmii_rxd[2:1];
        r_cand_duplex <= gmii_rxd[3];
        r_cnt         <= 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_DOWN;
      r_speed        <= DEFAULT_SPEED;
      r_link_up      <= 1'b0;
      r_full_duplex  <= 1'b0;
      r_mac_rst      <= 1'b1;
      r_speed_change <= 1'b0;
      r_pending      <= DEFAULT_SPEED;
      r_hold         <= 8'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_speed        <= w_speed_nxt;
      r_link_up      <= w_link_up_nxt;
      r_full_duplex  <= w_full_duplex_nxt;
      r_mac_rst      <= w_mac_rst_nxt;
      r_speed_change <= w_speed_change_nxt;
      r_pending      <= w_pending_nxt;
      r_hold         <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DOWN: begin
        if (w_qualified && r_cand_link)
          w_state_nxt = (w_tgt == r_speed) ? S_UP : S_DRAIN;
      end
      S_UP: begin
        if (w_qualified && !r_cand_link)
          w_state_nxt = S_DOWN;
        else if (w_qualified && (w_tgt != r_speed))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_hold_done) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_hold_done)
          w_state_nxt = (r_cand_link && w_qualified) ? S_UP : S_DOWN;
      end
      default: w_state_nxt = S_DOWN;
    endcase
  end

  // Next values of the registered outputs, derived from the current transition
  always_comb begin
    w_speed_nxt        = r_speed;
    w_link_up_nxt      = (w_state_nxt == S_UP);
    w_full_duplex_nxt  = r_full_duplex;
    w_mac_rst_nxt      = (w_state_nxt == S_DRAIN) || (w_state_nxt == S_SETTLE);
    w_speed_change_nxt = 1'b0;
    w_pending_nxt      = r_pending;
    w_hold_nxt         = 8'd0;
    if ((w_state_nxt == r_state) && ((r_state == S_DRAIN) || (r_state == S_SETTLE)))
      w_hold_nxt = r_hold + 8'd1;
    if ((r_state != S_DRAIN) && (w_state_nxt == S_DRAIN))
      w_pending_nxt = w_tgt;
    if ((r_state == S_DRAIN) && (w_state_nxt == S_SETTLE)) begin
      w_speed_nxt        = r_pending;
      w_speed_change_nxt = 1'b1;
    end
    if ((r_state == S_SETTLE) && (w_state_nxt != S_SETTLE))
      w_full_duplex_nxt = r_cand_duplex;
    if ((r_state == S_UP) && (w_state_nxt == S_UP) && w_qualified)
      w_full_duplex_nxt = r_cand_duplex;
  end

  assign speed        = r_speed;
  assign link_up      = r_link_up;
  assign full_duplex  = r_full_duplex;
  assign mac_rst      = r_mac_rst;
  assign speed_change = r_speed_change;

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// tb/tb_rgmii_link_ctrl.sv - scoreboard bench for rgmii_link_ctrl
// Expected output tuples {speed,link_up,full_duplex,mac_rst,speed_change} and their hold lengths are queued.
module tb_rgmii_link_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       cfg_force_en;
  logic [1:0] cfg_force_speed;
  logic [1:0] speed;
  logic       link_up;
  logic       full_duplex;
  logic       mac_rst;
  logic       speed_change;

  typedef struct {
    logic [5:0] tup;
    int         dur;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_pushed = 0;

  rgmii_link_ctrl #(
    .STABLE_COUNT (4),
    .HOLD_CYCLES  (3),
    .DEFAULT_SPEED(2'b10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .cfg_force_en   (cfg_force_en),
    .cfg_force_speed(cfg_force_speed),
    .speed          (speed),
    .link_up        (link_up),
    .full_duplex    (full_duplex),
    .mac_rst        (mac_rst),
    .speed_change   (speed_change)
  );

  always #5 clk = ~clk;

  // dur = exact cycles the tuple must persist; 0 = not checked
  task automatic push(input logic [1:0] sp, input logic lu, input logic fd,
                      input logic mr, input logic sc, input int dur);
    exp_t e;
    e.tup = {sp, lu, fd, mr, sc};
    e.dur = dur;
    e.idx = n_pushed;
    n_pushed++;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] m_cur;
  logic [5:0] m_prev;
  int         m_run;
  int         m_prev_dur;
  int         m_prev_idx;
  bit         m_first = 1'b1;
  exp_t       m_e;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      m_cur = {speed, link_up, full_duplex, mac_rst, speed_change};
      if (m_first || (m_cur !== m_prev)) begin
        if (!m_first && (m_prev_dur != 0)) begin
          checks++;
          if (m_run != m_prev_dur) begin
            failures++;
            $display("FAIL hold_len[%0d] tuple=%b cycles=%0d required=%0d",
                     m_prev_idx, m_prev, m_run, m_prev_dur);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got=%b required=no_change", m_cur);
          m_prev_dur = 0;
          m_prev_idx = -1;
        end else begin
          m_e = exp_q.pop_front();
          if (m_cur !== m_e.tup) begin
            failures++;
            $display("FAIL tuple[%0d] got=%b required=%b", m_e.idx, m_cur, m_e.tup);
          end
          m_prev_dur = m_e.dur;
          m_prev_idx = m_e.idx;
        end
        m_prev  = m_cur;
        m_run   = 1;
        m_first = 1'b0;
      end else begin
        m_run++;
      end
    end
  end

  initial begin
    rst             = 1'b1;
    gmii_rxd        = 8'h0D;
    gmii_rx_dv      = 1'b0;
    gmii_rx_er      = 1'b0;
    cfg_force_en    = 1'b0;
    cfg_force_speed = 2'b00;

    // Reset, then link qualifies at 1000M full duplex
    push(2'b10, 0, 0, 1, 0, 0);
    push(2'b10, 0, 0, 0, 0, 4);
    push(2'b10, 1, 0, 0, 0, 1);
    push(2'b10, 1, 1, 0, 0, 9);
    tick(3);
    rst = 1'b0;
    tick(10);

    // In-band switch to 100M
    push(2'b10, 0, 1, 1, 0, 3);
    push(2'b01, 0, 1, 1, 1, 1);
    push(2'b01, 0, 1, 1, 0, 2);
    push(2'b01, 1, 1, 0, 0, 28);
    gmii_rxd = 8'h0B;
    tick(14);

    // Link-down samples split by a frame and error cycles, then link back up
    push(2'b01, 0, 1, 0, 0, 4);
    push(2'b01, 1, 1, 0, 0, 11);
    gmii_rxd = 8'h0A;
    tick(3);
    gmii_rx_dv = 1'b1;
    gmii_rxd   = 8'h55;
    tick(18);
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b1;
    gmii_rxd   = 8'h0D;
    tick(2);
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h0A;
    tick(1);
    gmii_rxd = 8'h0B;
    tick(8);

    // Reserved sample clears the count; then DOWN -> switch back to 1000M
    push(2'b01, 0, 1, 0, 0, 4);
    push(2'b01, 0, 1, 1, 0, 3);
    push(2'b10, 0, 1, 1, 1, 1);
    push(2'b10, 0, 1, 1, 0, 2);
    push(2'b10, 1, 1, 0, 0, 12);
    gmii_rxd = 8'h0A;
    tick(2);
    gmii_rxd = 8'h07;
    tick(1);
    gmii_rxd = 8'h0A;
    tick(4);
    gmii_rxd = 8'h0D;
    tick(11);

    // Forced 11 maps to 1000M (no switch); forced 00 switches; cfg churn mid-sequence ignored
    push(2'b10, 0, 1, 1, 0, 3);
    push(2'b00, 0, 1, 1, 1, 1);
    push(2'b00, 0, 1, 1, 0, 2);
    push(2'b00, 1, 1, 0, 0, 4);
    cfg_force_en    = 1'b1;
    cfg_force_speed = 2'b11;
    tick(11);
    cfg_force_speed = 2'b00;
    tick(2);
    cfg_force_speed = 2'b01;
    tick(2);
    cfg_force_speed = 2'b00;
    tick(6);

    // Reset pulsed during DRAIN aborts the switch
    push(2'b00, 0, 1, 1, 0, 2);
    push(2'b10, 0, 0, 1, 0, 1);
    push(2'b10, 0, 0, 0, 0, 4);
    push(2'b10, 1, 0, 0, 0, 1);
    push(2'b10, 1, 1, 0, 0, 0);
    cfg_force_speed = 2'b10;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain outstanding=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
